// File: rtl/sdram_pkg.sv
// Shared definitions for the SDRAM read-stream client: default address
// width, FSM state encoding and the request/ack timeout limit.
package sdram_pkg;

  localparam int ADDR_W_DEFAULT = 22;
  localparam int DATA_W         = 16;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_ISSUE = 3'd1;
  localparam state_t ST_REQ   = 3'd2;
  localparam state_t ST_ACK   = 3'd3;
  localparam state_t ST_DONE  = 3'd4;

  localparam int              TMO_W       = 10;
  localparam logic [TMO_W-1:0] TIMEOUT_MAX = 10'd1023;

endpackage

// File: rtl/sdram_stream_fifo.sv
// First-word-fall-through FIFO between the SDRAM read client and the
// downstream stream. A simultaneous push and pop is accepted when full;
// a word written into an empty FIFO cannot pop in the same cycle.
module sdram_stream_fifo #(
  parameter int DEPTH = 8,
  parameter int DW    = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [DW-1:0]            din,
  output logic [DW-1:0]            dout,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  // Storage, pointers and occupancy; storage is cleared so dout reads 0 after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sdram_rd_stream.sv
// Sequential SDRAM read client: issues one single-word read at a time from
// start_addr for word_cnt words and streams the captured data out through
// a FWFT FIFO with valid/ready backpressure.
// Optional feature macro: SDRAM_RD_TIMEOUT_EN (request/ack watchdog, err flag).
//
// state    | meaning
// ---------+-------------------------------------------
// ST_IDLE  | waiting for start
// ST_ISSUE | waiting for a free FIFO slot
// ST_REQ   | sdram_rd_req held high until ack is seen
// ST_ACK   | waiting for ack to fall, then capture word
// ST_DONE  | final cycle before done pulses
module sdram_rd_stream
  import sdram_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = ADDR_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [15:0]       word_cnt,
  output logic              busy,
  output logic              done,
  output logic              sdram_rd_req,
  input  logic              sdram_rd_ack,
  output logic [ADDR_W-1:0] sys_addr,
  input  logic [15:0]       sys_data_out,
  output logic [15:0]       m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              err
);

  localparam int            CW       = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FIFO_CAP = CW'(DEPTH);

  state_t        state;
  logic [15:0]   remaining;
  logic          fifo_push;
  logic          fifo_pop;
  logic          fifo_empty;
  logic          fifo_full;
  logic [CW-1:0] fifo_count;
  logic          tmo_hit;

  // The word is captured on the first cycle ack is seen low in ST_ACK.
  assign fifo_push = (state == ST_ACK) && !sdram_rd_ack;
  assign fifo_pop  = m_valid && m_ready;
  assign m_valid   = !fifo_empty;

  sdram_stream_fifo #(
    .DEPTH (DEPTH),
    .DW    (DATA_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (sys_data_out),
    .dout  (m_data),
    .empty (fifo_empty),
    .full  (fifo_full),
    .count (fifo_count)
  );

`ifdef SDRAM_RD_TIMEOUT_EN
  logic [TMO_W-1:0] tmo_cnt;

  assign tmo_hit = ((state == ST_REQ) || (state == ST_ACK)) && (tmo_cnt == '0);

  // Watchdog down-counter, reloaded on entry to ST_REQ and to ST_ACK.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt <= TIMEOUT_MAX;
    end else if ((state != ST_REQ) && (state != ST_ACK)) begin
      tmo_cnt <= TIMEOUT_MAX;
    end else if ((state == ST_REQ) && sdram_rd_ack) begin
      tmo_cnt <= TIMEOUT_MAX;
    end else if (tmo_cnt != '0) begin
      tmo_cnt <= tmo_cnt - 1'b1;
    end
  end

  // Sticky timeout flag, cleared only by an accepted start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else if ((state == ST_IDLE) && start && !busy) begin
      err <= 1'b0;
    end else if (tmo_hit && !fifo_push && !((state == ST_REQ) && sdram_rd_ack)) begin
      err <= 1'b1;
    end
  end
`else
  assign tmo_hit = 1'b0;
  assign err     = 1'b0;
`endif

  // Main sequencing FSM with registered busy/done/request/address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      busy         <= 1'b0;
      done         <= 1'b0;
      sdram_rd_req <= 1'b0;
      sys_addr     <= '0;
      remaining    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          // busy stays up through the done cycle, so a start there is dropped.
          busy <= 1'b0;
          if (start && !busy) begin
            busy      <= 1'b1;
            sys_addr  <= start_addr;
            remaining <= word_cnt;
            state     <= (word_cnt == 16'd0) ? ST_DONE : ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (fifo_count < FIFO_CAP) begin
            sdram_rd_req <= 1'b1;
            state        <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (sdram_rd_ack) begin
            sdram_rd_req <= 1'b0;
            state        <= ST_ACK;
          end else if (tmo_hit) begin
            sdram_rd_req <= 1'b0;
            state        <= ST_DONE;
          end
        end
        ST_ACK: begin
          if (!sdram_rd_ack) begin
            sys_addr  <= sys_addr + 1'b1;
            remaining <= remaining - 1'b1;
            state     <= (remaining == 16'd1) ? ST_DONE : ST_ISSUE;
          end else if (tmo_hit) begin
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          done  <= 1'b1;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // One outstanding request means a push never lands on a full FIFO without a pop.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(fifo_push && fifo_full && !fifo_pop));

endmodule

// File: tb/tb_sdram_rd_stream.sv
// Directed bench for sdram_rd_stream with a simple controller model that
// acks each request for two cycles and returns data = address[15:0].
module tb_sdram_rd_stream;

  localparam int ADDR_W = 22;
  localparam int DEPTH  = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] start_addr = '0;
  logic [15:0]       word_cnt = '0;
  logic              busy;
  logic              done;
  logic              sdram_rd_req;
  logic              sdram_rd_ack = 1'b0;
  logic [ADDR_W-1:0] sys_addr;
  logic [15:0]       sys_data_out = '0;
  logic [15:0]       m_data;
  logic              m_valid;
  logic              m_ready = 1'b0;
  logic              err;

  int n_chk = 0;
  int n_err = 0;
  int done_cnt = 0;
  bit ctl_en = 1'b1;
  logic [ADDR_W-1:0] req_q[$];
  logic [15:0]       rx_q[$];

  sdram_rd_stream #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .start_addr   (start_addr),
    .word_cnt     (word_cnt),
    .busy         (busy),
    .done         (done),
    .sdram_rd_req (sdram_rd_req),
    .sdram_rd_ack (sdram_rd_ack),
    .sys_addr     (sys_addr),
    .sys_data_out (sys_data_out),
    .m_data       (m_data),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .err          (err)
  );

  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // controller model
  initial begin
    logic [ADDR_W-1:0] a;
    forever begin
      @(posedge clk); #1;
      if (ctl_en && rst_n && sdram_rd_req && !sdram_rd_ack) begin
        a = sys_addr;
        req_q.push_back(a);
        sdram_rd_ack = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        sdram_rd_ack = 1'b0;
        sys_data_out = a[15:0];
      end
    end
  end

  // stream and done monitor
  always @(negedge clk) begin
    if (rst_n) begin
      if (m_valid && m_ready) rx_q.push_back(m_data);
      if (done) done_cnt++;
    end
  end

  task automatic pulse_start(input logic [ADDR_W-1:0] a, input logic [15:0] n);
    @(posedge clk); #1;
    start_addr = a;
    word_cnt   = n;
    start      = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_done(input string tag, input int budget);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (done !== 1'b1 && k < budget);
    chk_eq(tag, done, 1);
  endtask

  task automatic clear_logs();
    req_q.delete();
    rx_q.delete();
    done_cnt = 0;
  endtask

  initial begin
    // reset values
    #12;
    chk_eq("rst busy", busy, 0);
    chk_eq("rst done", done, 0);
    chk_eq("rst req", sdram_rd_req, 0);
    chk_eq("rst addr", sys_addr, 0);
    chk_eq("rst valid", m_valid, 0);
    chk_eq("rst data", m_data, 0);
    chk_eq("rst err", err, 0);
    #11 rst_n = 1'b1;

    // basic 3-word read
    clear_logs();
    m_ready = 1'b1;
    pulse_start(22'h000100, 16'd3);
    @(negedge clk);
    chk_eq("launch busy", busy, 1);
    chk_eq("launch req early", sdram_rd_req, 0);
    @(negedge clk);
    chk_eq("launch req", sdram_rd_req, 1);
    chk_eq("launch addr", sys_addr, 22'h000100);
    wait_done("basic done", 100);
    chk_eq("basic busy at done", busy, 1);
    @(negedge clk);
    chk_eq("basic busy after", busy, 0);
    chk_eq("basic done width", done, 0);
    tick(5);
    chk_eq("basic nreq", req_q.size(), 3);
    chk_eq("basic nrx", rx_q.size(), 3);
    for (int i = 0; i < 3; i++) begin
      chk_eq($sformatf("basic req%0d", i), req_q[i], 22'h000100 + i);
      chk_eq($sformatf("basic rx%0d", i), rx_q[i], 16'h0100 + i);
    end
    chk_eq("basic ndone", done_cnt, 1);

    // backpressure: 12 words into an 8-deep FIFO
    clear_logs();
    m_ready = 1'b0;
    pulse_start(22'h000200, 16'd12);
    tick(150);
    chk_eq("bp nreq stall", req_q.size(), 8);
    chk_eq("bp req low", sdram_rd_req, 0);
    chk_eq("bp full", dut.u_fifo.full, 1);
    chk_eq("bp valid", m_valid, 1);
    chk_eq("bp head", m_data, 16'h0200);
    chk_eq("bp busy", busy, 1);
    @(posedge clk); #1;
    m_ready = 1'b1;
    wait_done("bp done", 300);
    tick(10);
    chk_eq("bp nreq", req_q.size(), 12);
    chk_eq("bp nrx", rx_q.size(), 12);
    for (int i = 0; i < 12; i++) begin
      chk_eq($sformatf("bp req%0d", i), req_q[i], 22'h000200 + i);
      chk_eq($sformatf("bp rx%0d", i), rx_q[i], 16'h0200 + i);
    end
    chk_eq("bp ndone", done_cnt, 1);

    // address wrap, words left in the FIFO
    clear_logs();
    @(posedge clk); #1;
    m_ready = 1'b0;
    pulse_start(22'h3FFFFF, 16'd2);
    wait_done("wrap done", 100);
    tick(3);
    chk_eq("wrap nreq", req_q.size(), 2);
    chk_eq("wrap req0", req_q[0], 22'h3FFFFF);
    chk_eq("wrap req1", req_q[1], 22'h000000);
    chk_eq("wrap addr after", sys_addr, 22'h000001);
    chk_eq("wrap valid", m_valid, 1);
    chk_eq("wrap head", m_data, 16'hFFFF);

    // zero-length transfer leaves the FIFO alone
    clear_logs();
    pulse_start(22'h001234, 16'd0);
    @(negedge clk);
    chk_eq("zero done T+1", done, 0);
    chk_eq("zero busy T+1", busy, 1);
    @(negedge clk);
    chk_eq("zero done T+2", done, 1);
    @(negedge clk);
    chk_eq("zero busy end", busy, 0);
    tick(3);
    chk_eq("zero nreq", req_q.size(), 0);
    chk_eq("zero fifo count", dut.u_fifo.count, 2);
    chk_eq("zero head", m_data, 16'hFFFF);
    chk_eq("zero addr latch", sys_addr, 22'h001234);
    @(posedge clk); #1;
    m_ready = 1'b1;
    tick(5);
    chk_eq("zero nrx", rx_q.size(), 2);
    chk_eq("zero rx0", rx_q[0], 16'hFFFF);
    chk_eq("zero rx1", rx_q[1], 16'h0000);

    // start re-pulsed mid-transfer is ignored
    clear_logs();
    pulse_start(22'h000500, 16'd4);
    tick(4);
    pulse_start(22'h000900, 16'd9);
    wait_done("restart done", 200);
    tick(5);
    chk_eq("restart nreq", req_q.size(), 4);
    chk_eq("restart nrx", rx_q.size(), 4);
    for (int i = 0; i < 4; i++) begin
      chk_eq($sformatf("restart req%0d", i), req_q[i], 22'h000500 + i);
      chk_eq($sformatf("restart rx%0d", i), rx_q[i], 16'h0500 + i);
    end
    chk_eq("restart ndone", done_cnt, 1);

`ifdef SDRAM_RD_TIMEOUT_EN
    // controller never acks
    clear_logs();
    ctl_en = 1'b0;
    pulse_start(22'h000010, 16'd1);
    wait_done("tmo done", 1200);
    chk_eq("tmo err", err, 1);
    chk_eq("tmo req low", sdram_rd_req, 0);
    chk_eq("tmo no push", m_valid, 0);
    tick(3);
    ctl_en = 1'b1;
    pulse_start(22'h000020, 16'd0);
    @(negedge clk);
    chk_eq("tmo err cleared", err, 0);
    tick(4);
`else
    chk_eq("err tied low", err, 0);
`endif

    // asynchronous reset mid-transfer
    clear_logs();
    m_ready = 1'b0;
    pulse_start(22'h000700, 16'd5);
    tick(20);
    chk_eq("rst2 pre valid", m_valid, 1);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk_eq("rst2 valid", m_valid, 0);
    chk_eq("rst2 busy", busy, 0);
    chk_eq("rst2 req", sdram_rd_req, 0);
    chk_eq("rst2 addr", sys_addr, 0);
    chk_eq("rst2 data", m_data, 0);
    chk_eq("rst2 done", done, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
